// File: rtl/vga_pkg.sv
// Shared VGA chain definitions: 800x600 active area, the timing/colour bundle
// passed between stages, and the cursor overlay modes and pixel codes.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef enum logic [1:0] {
        CUR_HIDDEN    = 2'd0,
        CUR_ARROW     = 2'd1,
        CUR_CROSSHAIR = 2'd2,
        CUR_RESERVED  = 2'd3
    } cursor_mode_t;

    localparam logic [1:0] PIX_TRANSP  = 2'd0;
    localparam logic [1:0] PIX_OUTLINE = 2'd1;
    localparam logic [1:0] PIX_FILL    = 2'd2;
    localparam logic [1:0] PIX_INVERT  = 2'd3;

endpackage

// File: rtl/vga_if.sv
// Timing plus colour bundle between VGA pipeline stages.
// Each stage consumes one through "in" and produces one through "out".
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/cursor_sprite_rom.sv
// Two W x H sprites of 2-bit pixel codes: arrow at index 0, crosshair at 1.
// Address is {index, row, col}; data appears one clock after the address.
module cursor_sprite_rom
    import vga_pkg::*;
#(
    parameter  int W  = 16,
    parameter  int H  = 16,
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(H)
) (
    input  logic             clk,
    input  logic [XW+YW:0]   addr,
    output logic [1:0]       data
);

    logic [1:0] data_q;
    logic [1:0] data_d;
    int         row;
    int         col;

    // Arrow: left-justified triangle with outlined edges and bottom row.
    // Crosshair: one inverting column and row through the sprite centre.
    always_comb begin
        row    = int'(addr[XW +: YW]);
        col    = int'(addr[XW-1:0]);
        data_d = PIX_TRANSP;
        if (addr[XW+YW]) begin
            if (col == W / 2 || row == H / 2) begin
                data_d = PIX_INVERT;
            end
        end else if (col <= row) begin
            if (col == 0 || col == row || row == H - 1) begin
                data_d = PIX_OUTLINE;
            end else begin
                data_d = PIX_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/draw_cursor.sv
// Pipelined mouse-cursor overlay: sprite drawn over the incoming picture at
// a position and mode sampled once per frame, with 2 cycles of latency.
module draw_cursor
    import vga_pkg::*;
#(
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          HOT_X       = 0,
    parameter int          HOT_Y       = 0,
    parameter logic [11:0] COL_OUTLINE = 12'h000,
    parameter logic [11:0] COL_FILL    = 12'hFFF
) (
    input  logic        clk40MHz,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [1:0]  mode,
    vga_if.in           in,
    vga_if.out          out
);

    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);

    logic [11:0]        x_lat_q, x_lat_d;
    logic [11:0]        y_lat_q, y_lat_d;
    cursor_mode_t       mode_lat_q, mode_lat_d;
    logic               vblnk_prev_q, vblnk_prev_d;
    vga_t               s1_q, s1_d;
    vga_t               s2_q, s2_d;
    logic               inside_q, inside_d;

    logic signed [12:0] ox, oy;
    logic signed [12:0] dx, dy;
    logic               blank;
    logic               visible;
    logic               on_screen;
    logic [XW+YW:0]     rom_addr;
    logic [1:0]         pix;

    always_comb begin
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        mode_lat_d   = mode_lat_q;
        vblnk_prev_d = in.vblnk;
        if (in.vblnk && !vblnk_prev_q) begin
            x_lat_d    = xpos;
            y_lat_d    = ypos;
            mode_lat_d = cursor_mode_t'(mode);
        end
    end

    always_comb begin
        ox        = $signed({1'b0, x_lat_q}) - 13'(HOT_X);
        oy        = $signed({1'b0, y_lat_q}) - 13'(HOT_Y);
        dx        = $signed({2'b00, in.hcount}) - ox;
        dy        = $signed({2'b00, in.vcount}) - oy;
        blank     = in.hblnk | in.vblnk;
        visible   = (mode_lat_q == CUR_ARROW) ||
                    (mode_lat_q == CUR_CROSSHAIR);
        on_screen = (32'(in.hcount) < H_ACTIVE) &&
                    (32'(in.vcount) < V_ACTIVE);
        inside_d  = !dx[12] && (dx < 13'(SPRITE_W)) &&
                    !dy[12] && (dy < 13'(SPRITE_H)) &&
                    !blank && on_screen && visible;
        // Bit 1 of the mode picks the sprite: ARROW=01 -> 0, CROSSHAIR=10 -> 1.
        rom_addr  = {mode_lat_q[1], dy[YW-1:0], dx[XW-1:0]};

        s1_d.hcount = in.hcount;
        s1_d.vcount = in.vcount;
        s1_d.hsync  = in.hsync;
        s1_d.vsync  = in.vsync;
        s1_d.hblnk  = in.hblnk;
        s1_d.vblnk  = in.vblnk;
        s1_d.rgb    = in.rgb;
    end

    cursor_sprite_rom #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_rom (
        .clk  (clk40MHz),
        .addr (rom_addr),
        .data (pix)
    );

    always_comb begin
        s2_d = s1_q;
        if (inside_q) begin
            unique case (pix)
                PIX_OUTLINE: s2_d.rgb = COL_OUTLINE;
                PIX_FILL:    s2_d.rgb = COL_FILL;
                PIX_INVERT:  s2_d.rgb = ~s1_q.rgb;
                default:     s2_d.rgb = s1_q.rgb;
            endcase
        end
    end

    // The edge detector resets high so a reset released inside vertical
    // blanking cannot be mistaken for a new frame and latch a cursor early.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            mode_lat_q   <= CUR_HIDDEN;
            vblnk_prev_q <= 1'b1;
            s1_q         <= '0;
            s2_q         <= '0;
            inside_q     <= 1'b0;
        end else begin
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            mode_lat_q   <= mode_lat_d;
            vblnk_prev_q <= vblnk_prev_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            inside_q     <= inside_d;
        end
    end

    assign out.hcount = s2_q.hcount;
    assign out.vcount = s2_q.vcount;
    assign out.hsync  = s2_q.hsync;
    assign out.vsync  = s2_q.vsync;
    assign out.hblnk  = s2_q.hblnk;
    assign out.vblnk  = s2_q.vblnk;
    assign out.rgb    = s2_q.rgb;

endmodule
